// File: rtl/nand_ecc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : nand_ecc_pkg
// Description : Shared constants, FSM state encoding and helpers for the
//               NAND ECC path (hamming_ecc_gen, hamming_xor, spare-area
//               writer).
// Contents    : ECC_W / BLOCK_BYTES / ECC_BYTES sizing, ecc_state_e,
//               MODE_WRITE / MODE_READ, col_mask() column-parity helper.
// Revision    : 1.0 - initial release
// ============================================================================
package nand_ecc_pkg;

  localparam int BLOCK_BYTES = 512;
  localparam int ECC_BYTES   = 3;
  localparam int BYTE_IDX_W  = $clog2(BLOCK_BYTES);
  localparam int ADDR_W      = BYTE_IDX_W + 3;
  localparam int ECC_W       = 2 * ADDR_W;

  localparam logic MODE_WRITE = 1'b0;
  localparam logic MODE_READ  = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DATA = 2'd1,
    ST_ECC  = 2'd2,
    ST_DONE = 2'd3
  } ecc_state_e;

  // Mask of the bit positions j (0..7) within a byte whose bit-address
  // bit k is set; used for the three column-parity pairs.
  function automatic logic [7:0] col_mask(input int k);
    logic [7:0] m;
    m = '0;
    for (int j = 0; j < 8; j++) begin
      m[j] = 1'(((j >> k) & 1) != 0);
    end
    return m;
  endfunction

endpackage : nand_ecc_pkg
`default_nettype wire

// File: rtl/hamming_byte_par.sv
`default_nettype none
// ============================================================================
// Module      : hamming_byte_par
// Description : Combinational per-byte contribution to the sector Hamming
//               ECC. XOR-ing the contributions of every byte of the sector
//               yields the full ECC.
// Ports       : din          in  8      data byte
//               byte_idx     in  IDX_W  index of the byte within the sector
//               ecc_contrib  out ECC_W  contribution of this byte
// Revision    : 1.0 - initial release
// ============================================================================
module hamming_byte_par #(
  parameter  int BLOCK_BYTES = nand_ecc_pkg::BLOCK_BYTES,
  localparam int IDX_W       = $clog2(BLOCK_BYTES),
  localparam int ECC_W       = 2 * (IDX_W + 3)
) (
  input  logic [7:0]       din,
  input  logic [IDX_W-1:0] byte_idx,
  output logic [ECC_W-1:0] ecc_contrib
);
  import nand_ecc_pkg::*;

  logic byte_par;
  assign byte_par = ^din;

  // Column pairs: address bits 0..2 select bits inside the byte.
  for (genvar k = 0; k < 3; k++) begin : g_col
    localparam logic [7:0] MASK = col_mask(k);
    assign ecc_contrib[2*k+1] = ^(din & MASK);
    assign ecc_contrib[2*k]   = ^(din & ~MASK);
  end

  // Line pairs: address bits 3.. come from the byte index, so the whole
  // byte parity lands in either the odd or the even bit of the pair.
  for (genvar k = 3; k < IDX_W + 3; k++) begin : g_line
    assign ecc_contrib[2*k+1] = byte_par &  byte_idx[k-3];
    assign ecc_contrib[2*k]   = byte_par & ~byte_idx[k-3];
  end

endmodule : hamming_byte_par
`default_nettype wire

// File: rtl/hamming_ecc_gen.sv
`default_nettype none
// ============================================================================
// Module      : hamming_ecc_gen
// Description : Streams a NAND sector byte-wise and accumulates its Hamming
//               ECC. In read mode the stored ECC bytes that follow the sector
//               are absorbed (little-endian) and computed^stored is emitted
//               for the downstream hamming_xor classifier.
// Ports       : clk            in   1      clock, posedge
//               rst            in   1      synchronous active-high reset
//               start          in   1      pulse: abort/clear, sample mode_rd
//               mode_rd        in   1      1 = read (compare), 0 = write
//               din            in   8      data byte / stored ECC byte
//               din_valid      in   1      byte strobe (DATA/ECC states)
//               busy           out  1      in DATA or ECC state
//               ecc_out        out  ECC_W  computed ECC, held
//               ecc_valid      out  1      pulse, ecc_out just updated
//               hamming_result out  ECC_W  computed ^ stored, held
//               hamming_en     out  1      pulse, hamming_result just updated
// Config      : HAMMING_ERASED_SKIP_EN - when defined, a read where every
//               accepted byte is 8'hFF reports hamming_result = 0.
// Revision    : 1.0 - initial release
// ============================================================================
module hamming_ecc_gen #(
  parameter  int BLOCK_BYTES = nand_ecc_pkg::BLOCK_BYTES,
  parameter  int ECC_BYTES   = nand_ecc_pkg::ECC_BYTES,
  localparam int IDX_W       = $clog2(BLOCK_BYTES),
  localparam int ECC_W       = 2 * (IDX_W + 3)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             mode_rd,
  input  logic [7:0]       din,
  input  logic             din_valid,
  output logic             busy,
  output logic [ECC_W-1:0] ecc_out,
  output logic             ecc_valid,
  output logic [ECC_W-1:0] hamming_result,
  output logic             hamming_en
);
  import nand_ecc_pkg::*;

  localparam int STORE_W = 8 * ECC_BYTES;
  localparam int ECNT_W  = (ECC_BYTES > 1) ? $clog2(ECC_BYTES) : 1;
  localparam logic [IDX_W-1:0]  LAST_BYTE = IDX_W'(BLOCK_BYTES - 1);
  localparam logic [ECNT_W-1:0] LAST_ECC  = ECNT_W'(ECC_BYTES - 1);

  ecc_state_e          state_q,     state_d;
  logic                mode_q,      mode_d;
  logic [IDX_W-1:0]    byte_cnt_q,  byte_cnt_d;
  logic [ECNT_W-1:0]   ecc_cnt_q,   ecc_cnt_d;
  logic [ECC_W-1:0]    acc_q,       acc_d;
  logic [STORE_W-1:0]  stored_q,    stored_d;
  logic [ECC_W-1:0]    ecc_out_q,   ecc_out_d;
  logic                ecc_valid_q, ecc_valid_d;
  logic [ECC_W-1:0]    ham_res_q,   ham_res_d;
  logic                ham_en_q,    ham_en_d;
`ifdef HAMMING_ERASED_SKIP_EN
  logic                erased_q,    erased_d;
`endif

  logic [ECC_W-1:0]    byte_contrib;
  logic [ECC_W-1:0]    acc_next;

  hamming_byte_par #(
    .BLOCK_BYTES (BLOCK_BYTES)
  ) u_byte_par (
    .din         (din),
    .byte_idx    (byte_cnt_q),
    .ecc_contrib (byte_contrib)
  );

  assign acc_next = acc_q ^ byte_contrib;

  always_comb begin
    state_d     = state_q;
    mode_d      = mode_q;
    byte_cnt_d  = byte_cnt_q;
    ecc_cnt_d   = ecc_cnt_q;
    acc_d       = acc_q;
    stored_d    = stored_q;
    ecc_out_d   = ecc_out_q;
    ecc_valid_d = 1'b0;
    ham_res_d   = ham_res_q;
    ham_en_d    = 1'b0;
`ifdef HAMMING_ERASED_SKIP_EN
    erased_d    = erased_q;
`endif

    if (start) begin
      // Abort whatever is in flight; the byte offered this cycle is dropped.
      state_d    = ST_DATA;
      mode_d     = mode_rd;
      byte_cnt_d = '0;
      ecc_cnt_d  = '0;
      acc_d      = '0;
      stored_d   = '0;
`ifdef HAMMING_ERASED_SKIP_EN
      erased_d   = 1'b1;
`endif
    end else begin
      case (state_q)
        ST_DATA: begin
          if (din_valid) begin
            acc_d = acc_next;
`ifdef HAMMING_ERASED_SKIP_EN
            erased_d = erased_q && (din == 8'hFF);
`endif
            // Terminal count is explicit so the counter never wraps.
            if (byte_cnt_q == LAST_BYTE) begin
              ecc_out_d   = acc_next;
              ecc_valid_d = 1'b1;
              state_d     = (mode_q == MODE_READ) ? ST_ECC : ST_DONE;
            end else begin
              byte_cnt_d = byte_cnt_q + 1'b1;
            end
          end
        end

        ST_ECC: begin
          if (din_valid) begin
            for (int b = 0; b < ECC_BYTES; b++) begin
              if (ecc_cnt_q == ECNT_W'(b)) begin
                stored_d[8*b +: 8] = din;
              end
            end
`ifdef HAMMING_ERASED_SKIP_EN
            erased_d = erased_q && (din == 8'hFF);
`endif
            if (ecc_cnt_q == LAST_ECC) begin
`ifdef HAMMING_ERASED_SKIP_EN
              ham_res_d = erased_d ? '0 : (ecc_out_q ^ stored_d[ECC_W-1:0]);
`else
              ham_res_d = ecc_out_q ^ stored_d[ECC_W-1:0];
`endif
              ham_en_d  = 1'b1;
              state_d   = ST_DONE;
            end else begin
              ecc_cnt_d = ecc_cnt_q + 1'b1;
            end
          end
        end

        default: begin
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      mode_q      <= MODE_WRITE;
      byte_cnt_q  <= '0;
      ecc_cnt_q   <= '0;
      acc_q       <= '0;
      stored_q    <= '0;
      ecc_out_q   <= '0;
      ecc_valid_q <= 1'b0;
      ham_res_q   <= '0;
      ham_en_q    <= 1'b0;
`ifdef HAMMING_ERASED_SKIP_EN
      erased_q    <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      byte_cnt_q  <= byte_cnt_d;
      ecc_cnt_q   <= ecc_cnt_d;
      acc_q       <= acc_d;
      stored_q    <= stored_d;
      ecc_out_q   <= ecc_out_d;
      ecc_valid_q <= ecc_valid_d;
      ham_res_q   <= ham_res_d;
      ham_en_q    <= ham_en_d;
`ifdef HAMMING_ERASED_SKIP_EN
      erased_q    <= erased_d;
`endif
    end
  end

  assign busy           = (state_q == ST_DATA) || (state_q == ST_ECC);
  assign ecc_out        = ecc_out_q;
  assign ecc_valid      = ecc_valid_q;
  assign hamming_result = ham_res_q;
  assign hamming_en     = ham_en_q;

endmodule : hamming_ecc_gen
`default_nettype wire

// File: tb/tb_hamming_ecc_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_hamming_ecc_gen
// Description : Self-checking bench for hamming_ecc_gen: directed sector
//               vectors from a table, random clean sectors, abort and reset
//               sequences.
// Config      : HAMMING_ERASED_SKIP_EN selects the erased-page expectation.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hamming_ecc_gen;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        mode_rd;
  logic [7:0]  din;
  logic        din_valid;
  logic        busy;
  logic [23:0] ecc_out;
  logic        ecc_valid;
  logic [23:0] hamming_result;
  logic        hamming_en;

  hamming_ecc_gen dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .mode_rd        (mode_rd),
    .din            (din),
    .din_valid      (din_valid),
    .busy           (busy),
    .ecc_out        (ecc_out),
    .ecc_valid      (ecc_valid),
    .hamming_result (hamming_result),
    .hamming_en     (hamming_en)
  );

  always #5 clk = ~clk;

`ifdef HAMMING_ERASED_SKIP_EN
  localparam logic [23:0] ERASED_RES = 24'h000000;
`else
  localparam logic [23:0] ERASED_RES = 24'hFFFFFF;
`endif

  int checks = 0;
  int errors = 0;
  int ev_cnt = 0;
  int he_cnt = 0;

  logic [7:0] sec [512];

  typedef struct {
    logic        md;
    logic [7:0]  fill;
    int          sidx;
    logic [7:0]  sval;
    logic [23:0] stored;
    logic [23:0] exp_ecc;
    logic [23:0] exp_res;
  } vec_t;

  localparam int NV = 7;
  vec_t vecs [NV];

  // Pulse counters sampled just after each active edge.
  always @(posedge clk) begin
    #1;
    if (ecc_valid)  ev_cnt++;
    if (hamming_en) he_cnt++;
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic fill_sector(input logic [7:0] fill, input int sidx, input logic [7:0] sval);
    for (int i = 0; i < 512; i++) sec[i] = fill;
    if (sidx >= 0) sec[sidx] = sval;
  endtask

  // Bit-address reference: every set bit at address A toggles ecc[2k+1]
  // when A[k] is 1, otherwise ecc[2k].
  function automatic logic [23:0] model_ecc();
    logic [23:0] e;
    logic [11:0] a;
    e = '0;
    for (int i = 0; i < 512; i++) begin
      for (int b = 0; b < 8; b++) begin
        if (sec[i][b]) begin
          a = {i[8:0], b[2:0]};
          for (int k = 0; k < 12; k++) begin
            if (a[k]) e[2*k+1] = ~e[2*k+1];
            else      e[2*k]   = ~e[2*k];
          end
        end
      end
    end
    return e;
  endfunction

  task automatic run_sector(input logic md, input logic [23:0] stored, input bit gaps);
    int total;
    total = md ? 515 : 512;
    @(negedge clk);
    start = 1'b1; mode_rd = md; din_valid = 1'b1; din = 8'hFF;
    @(negedge clk);
    start = 1'b0; din_valid = 1'b0;
    check("busy_after_start", busy, 1);
    for (int n = 0; n < total; n++) begin
      if (gaps && ($urandom_range(0, 3) == 0)) begin
        din_valid = 1'b0; din = 8'($urandom);
        @(negedge clk);
      end
      din = (n < 512) ? sec[n] : stored[(n-512)*8 +: 8];
      din_valid = 1'b1;
      @(negedge clk);
      if (n == 511) check("ecc_valid_timing", ecc_valid, 1);
      if (md && (n == total - 1)) check("hamming_en_timing", hamming_en, 1);
    end
    din_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("busy_done", busy, 0);
  endtask

  initial begin
    logic [23:0] mdl;

    vecs[0] = '{md:1'b0, fill:8'h00, sidx:0,   sval:8'h01, stored:24'h0,      exp_ecc:24'h555555, exp_res:24'h0};
    vecs[1] = '{md:1'b0, fill:8'h00, sidx:511, sval:8'h80, stored:24'h0,      exp_ecc:24'hAAAAAA, exp_res:24'h0};
    vecs[2] = '{md:1'b0, fill:8'h00, sidx:-1,  sval:8'h00, stored:24'h0,      exp_ecc:24'h000000, exp_res:24'h0};
    vecs[3] = '{md:1'b1, fill:8'hFF, sidx:-1,  sval:8'h00, stored:24'hFFFFFF, exp_ecc:24'h000000, exp_res:ERASED_RES};
    vecs[4] = '{md:1'b1, fill:8'h00, sidx:16,  sval:8'h01, stored:24'h559555, exp_ecc:24'h559555, exp_res:24'h000000};
    vecs[5] = '{md:1'b1, fill:8'h00, sidx:-1,  sval:8'h00, stored:24'h030201, exp_ecc:24'h000000, exp_res:24'h030201};
    vecs[6] = '{md:1'b1, fill:8'h00, sidx:165, sval:8'h08, stored:24'h000000, exp_ecc:24'h66599A, exp_res:24'h66599A};

    rst = 1'b1; start = 1'b0; mode_rd = 1'b0; din = 8'h00; din_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_ecc_out", ecc_out, 0);
    check("rst_ecc_valid", ecc_valid, 0);
    check("rst_result", hamming_result, 0);
    check("rst_hamming_en", hamming_en, 0);
    rst = 1'b0;

    // Bytes offered in IDLE must be ignored.
    din_valid = 1'b1; din = 8'h5A;
    repeat (4) @(negedge clk);
    din_valid = 1'b0;
    check("idle_ignores_din", busy, 0);

    for (int v = 0; v < NV; v++) begin
      fill_sector(vecs[v].fill, vecs[v].sidx, vecs[v].sval);
      ev_cnt = 0; he_cnt = 0;
      run_sector(vecs[v].md, vecs[v].stored, 1'b0);
      check($sformatf("v%0d_ecc_out", v), ecc_out, vecs[v].exp_ecc);
      check($sformatf("v%0d_ecc_valid_cnt", v), ev_cnt, 1);
      check($sformatf("v%0d_hamming_en_cnt", v), he_cnt, vecs[v].md ? 1 : 0);
      if (vecs[v].md) check($sformatf("v%0d_result", v), hamming_result, vecs[v].exp_res);
    end

    // Reset in the middle of a sector clears everything back to IDLE.
    fill_sector(8'h00, 7, 8'h24);
    @(negedge clk);
    start = 1'b1; mode_rd = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int n = 0; n < 50; n++) begin
      din = sec[n]; din_valid = 1'b1;
      @(negedge clk);
    end
    rst = 1'b1; din_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_busy", busy, 0);
    check("midrst_ecc_out", ecc_out, 0);
    check("midrst_result", hamming_result, 0);
    check("midrst_ecc_valid", ecc_valid, 0);
    check("midrst_hamming_en", hamming_en, 0);
    ev_cnt = 0;
    for (int n = 0; n < 600; n++) begin
      din = 8'h00; din_valid = 1'b1;
      @(negedge clk);
    end
    din_valid = 1'b0;
    check("postrst_no_pulse", ev_cnt, 0);
    check("postrst_busy", busy, 0);

    // Random sector: write pass, then clean read pass with gaps.
    for (int i = 0; i < 512; i++) sec[i] = 8'($urandom);
    mdl = model_ecc();
    ev_cnt = 0; he_cnt = 0;
    run_sector(1'b0, 24'h0, 1'b0);
    check("rand_wr_ecc", ecc_out, {8'h00, mdl});
    check("rand_wr_hen_cnt", he_cnt, 0);
    ev_cnt = 0; he_cnt = 0;
    run_sector(1'b1, mdl, 1'b1);
    check("rand_rd_ecc", ecc_out, {8'h00, mdl});
    check("rand_rd_result", hamming_result, 0);
    check("rand_rd_hen_cnt", he_cnt, 1);

    // Abort after 100 bytes, then a full clean sector.
    for (int i = 0; i < 512; i++) sec[i] = 8'($urandom);
    mdl = model_ecc();
    ev_cnt = 0; he_cnt = 0;
    @(negedge clk);
    start = 1'b1; mode_rd = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int n = 0; n < 100; n++) begin
      din = 8'($urandom); din_valid = 1'b1;
      @(negedge clk);
    end
    din_valid = 1'b0;
    check("abort_no_ecc_valid", ev_cnt, 0);
    run_sector(1'b1, mdl, 1'b0);
    check("abort_ecc", ecc_out, {8'h00, mdl});
    check("abort_result", hamming_result, 0);
    check("abort_ecc_valid_cnt", ev_cnt, 1);
    check("abort_hen_cnt", he_cnt, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_hamming_ecc_gen
`default_nettype wire
